// File: rtl/ls_address_queue_scheduler_pkg.sv
// Shared types and constants for the load/store address queue.
package lsu_pkg;

   localparam logic LOAD  = 1'b0;
   localparam logic STORE = 1'b1;

   localparam int DEF_BW_PROCESSOR_DATA = 32;
   localparam int DEF_BW_ADDRESS        = 32;
   localparam int DEF_BW_TAG            = 4;
   localparam int DEF_AQ_LENGTH         = 10;

   localparam int BW_AQ_IDX = $clog2(DEF_AQ_LENGTH);
   localparam int BW_AQ_CNT = $clog2(DEF_AQ_LENGTH + 1);

   typedef struct packed {
      logic                             valid;
      logic                             opcode;
      logic [DEF_BW_TAG-1:0]            tag;
      logic                             addr_valid;
      logic [DEF_BW_ADDRESS-1:0]        addr;
      logic [DEF_BW_PROCESSOR_DATA-1:0] wdata;
      logic                             issued;
   } aq_entry_t;

endpackage

// File: rtl/ls_address_queue_scheduler_select.sv
// Circular priority encoder: first request found walking from i_head forward
// (oldest first) or, with REVERSE=1, walking backward (youngest first).
module age_priority_select #(
   parameter int N       = 10,
   parameter int BW_IDX  = 4,
   parameter bit REVERSE = 1'b0
) (
   input  logic [N-1:0]      i_req,
   input  logic [BW_IDX-1:0] i_head,
   output logic              o_found,
   output logic [BW_IDX-1:0] o_idx
);

   always_comb begin
      int pos;
      pos     = 0;
      o_found = 1'b0;
      o_idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (REVERSE) begin
            pos = int'(i_head) - k;
            if (pos < 0) pos = pos + N;
         end else begin
            pos = int'(i_head) + k;
            if (pos >= N) pos = pos - N;
         end
         if (!o_found && i_req[pos]) begin
            o_found = 1'b1;
            o_idx   = BW_IDX'(pos);
         end
      end
   end

endmodule

// File: rtl/ls_address_queue_scheduler.sv
// Program-order address queue: in-order alloc, tag-based resolve, head-only
// store issue, out-of-order load issue with store-to-load forwarding.
module ls_address_queue_scheduler
   import lsu_pkg::*;
#(
   parameter int BW_PROCESSOR_DATA = 32,
   parameter int BW_ADDRESS        = 32,
   parameter int BW_TAG            = 4,
   parameter int AQ_LENGTH         = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_flush,
   input  logic                         i_alloc_valid,
   output logic                         i_alloc_ready,
   input  logic                         i_alloc_opcode,
   input  logic [BW_TAG-1:0]            i_alloc_tag,
   input  logic                         i_exec_valid,
   input  logic [BW_TAG-1:0]            i_exec_tag,
   input  logic [BW_ADDRESS-1:0]        i_exec_addr,
   input  logic [BW_PROCESSOR_DATA-1:0] i_exec_wdata,
   output logic                         o_lsrsv_valid,
   input  logic                         o_lsrsv_ready,
   output logic                         o_lsrsv_opcode,
   output logic [BW_TAG-1:0]            o_lsrsv_tag,
   output logic [BW_ADDRESS-1:0]        o_lsrsv_rwaddr,
   output logic [BW_PROCESSOR_DATA-1:0] o_lsrsv_wdata,
   output logic                         o_lsrsv_load_forwarding_valid,
   output logic [BW_PROCESSOR_DATA-1:0] o_lsrsv_load_forwarding_data
);

   localparam int BW_IDX = $clog2(AQ_LENGTH);
   localparam int BW_CNT = $clog2(AQ_LENGTH + 1);
   localparam logic [BW_IDX-1:0] LAST_IDX = BW_IDX'(AQ_LENGTH - 1);
   localparam logic [BW_IDX-1:0] NUM_IDX  = BW_IDX'(AQ_LENGTH);
   localparam logic [BW_CNT-1:0] FULL_CNT = BW_CNT'(AQ_LENGTH);

   logic [AQ_LENGTH-1:0]         r_valid, r_opcode, r_addr_valid, r_issued;
   logic [BW_TAG-1:0]            r_tag   [AQ_LENGTH];
   logic [BW_ADDRESS-1:0]        r_addr  [AQ_LENGTH];
   logic [BW_PROCESSOR_DATA-1:0] r_wdata [AQ_LENGTH];
   logic [BW_IDX-1:0]            r_head, r_tail, r_lock_idx;
   logic [BW_CNT-1:0]            r_count;
   logic                         r_lock;

   logic                         r_hold_opcode, r_hold_fwd_valid;
   logic [BW_TAG-1:0]            r_hold_tag;
   logic [BW_ADDRESS-1:0]        r_hold_addr;
   logic [BW_PROCESSOR_DATA-1:0] r_hold_wdata, r_hold_fwd_data;

   logic [BW_IDX-1:0]    w_age [AQ_LENGTH];
   logic [AQ_LENGTH-1:0] w_unres, w_elig, w_fwd_req;
   logic                 w_unres_found, w_sel_found, w_fwd_found, w_fwd_hit;
   logic [BW_IDX-1:0]    w_unres_idx, w_unres_age, w_sel_idx, w_sel_prev, w_fwd_idx;
   logic [BW_IDX-1:0]    w_issue_idx;
   logic                 w_fire, w_pop, w_alloc, w_issue_opcode;

   logic                         w_cur_opcode;
   logic [BW_TAG-1:0]            w_cur_tag;
   logic [BW_ADDRESS-1:0]        w_cur_addr;
   logic [BW_PROCESSOR_DATA-1:0] w_cur_wdata, w_cur_fwd_data;

   function automatic logic [BW_IDX-1:0] f_next(input logic [BW_IDX-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Age relative to head; valid entries are contiguous from head so this orders them.
   genvar gi;
   generate
      for (gi = 0; gi < AQ_LENGTH; gi++) begin : g_entry
         localparam logic [BW_IDX-1:0] IDX = BW_IDX'(gi);
         assign w_age[gi]   = (IDX >= r_head) ? (IDX - r_head) : (IDX + NUM_IDX - r_head);
         assign w_unres[gi] = r_valid[gi] && (r_opcode[gi] == STORE) && !r_addr_valid[gi];
         assign w_elig[gi]  = r_valid[gi] && r_addr_valid[gi] && !r_issued[gi] &&
                              ((r_opcode[gi] == STORE) ? (IDX == r_head)
                                                       : (!w_unres_found || (w_age[gi] < w_unres_age)));
         assign w_fwd_req[gi] = r_valid[gi] && (r_opcode[gi] == STORE) && r_addr_valid[gi] &&
                                (r_addr[gi] == w_cur_addr) && (w_age[gi] < w_age[w_sel_idx]);
      end
   endgenerate

   age_priority_select #(.N(AQ_LENGTH), .BW_IDX(BW_IDX), .REVERSE(1'b0)) u_unres_sel (
      .i_req   (w_unres),
      .i_head  (r_head),
      .o_found (w_unres_found),
      .o_idx   (w_unres_idx)
   );

   age_priority_select #(.N(AQ_LENGTH), .BW_IDX(BW_IDX), .REVERSE(1'b0)) u_issue_sel (
      .i_req   (w_elig),
      .i_head  (r_head),
      .o_found (w_sel_found),
      .o_idx   (w_sel_idx)
   );

   // Walking backward from just below the load finds the youngest older store first.
   age_priority_select #(.N(AQ_LENGTH), .BW_IDX(BW_IDX), .REVERSE(1'b1)) u_fwd_sel (
      .i_req   (w_fwd_req),
      .i_head  (w_sel_prev),
      .o_found (w_fwd_found),
      .o_idx   (w_fwd_idx)
   );

   assign w_unres_age    = w_age[w_unres_idx];
   assign w_sel_prev     = (w_sel_idx == '0) ? LAST_IDX : w_sel_idx - 1'b1;
   assign w_cur_opcode   = r_opcode[w_sel_idx];
   assign w_cur_tag      = r_tag[w_sel_idx];
   assign w_cur_addr     = r_addr[w_sel_idx];
   assign w_cur_wdata    = r_wdata[w_sel_idx];
   assign w_fwd_hit      = w_sel_found && (w_cur_opcode == LOAD) && w_fwd_found;
   assign w_cur_fwd_data = w_fwd_hit ? r_wdata[w_fwd_idx] : '0;

   assign i_alloc_ready  = (r_count < FULL_CNT) && !i_flush;
   assign w_alloc        = i_alloc_valid && i_alloc_ready;
   assign o_lsrsv_valid  = !i_flush && (r_lock || w_sel_found);
   assign w_fire         = o_lsrsv_valid && o_lsrsv_ready;
   assign w_issue_idx    = r_lock ? r_lock_idx : w_sel_idx;
   assign w_issue_opcode = r_lock ? r_hold_opcode : w_cur_opcode;
   assign w_pop          = (w_fire && (w_issue_opcode == STORE)) ||
                           (r_valid[r_head] && (r_opcode[r_head] == LOAD) && r_issued[r_head]);

   assign o_lsrsv_opcode = o_lsrsv_valid && (r_lock ? r_hold_opcode : w_cur_opcode);
   assign o_lsrsv_tag    = !o_lsrsv_valid ? '0 : (r_lock ? r_hold_tag   : w_cur_tag);
   assign o_lsrsv_rwaddr = !o_lsrsv_valid ? '0 : (r_lock ? r_hold_addr  : w_cur_addr);
   assign o_lsrsv_wdata  = !o_lsrsv_valid ? '0 : (r_lock ? r_hold_wdata : w_cur_wdata);
   assign o_lsrsv_load_forwarding_valid = o_lsrsv_valid && (r_lock ? r_hold_fwd_valid : w_fwd_hit);
   assign o_lsrsv_load_forwarding_data  = !o_lsrsv_valid ? '0 :
                                          (r_lock ? r_hold_fwd_data : w_cur_fwd_data);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid          <= '0;
         r_opcode         <= '0;
         r_addr_valid     <= '0;
         r_issued         <= '0;
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_lock           <= 1'b0;
         r_lock_idx       <= '0;
         r_hold_opcode    <= 1'b0;
         r_hold_tag       <= '0;
         r_hold_addr      <= '0;
         r_hold_wdata     <= '0;
         r_hold_fwd_valid <= 1'b0;
         r_hold_fwd_data  <= '0;
         for (int i = 0; i < AQ_LENGTH; i++) begin
            r_tag[i]   <= '0;
            r_addr[i]  <= '0;
            r_wdata[i] <= '0;
         end
      end else if (i_flush) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_lock  <= 1'b0;
      end else begin
         // The tail slot is always free when allocating, so none of these writes collide.
         if (w_alloc) begin
            r_valid[r_tail]      <= 1'b1;
            r_opcode[r_tail]     <= i_alloc_opcode;
            r_tag[r_tail]        <= i_alloc_tag;
            r_addr_valid[r_tail] <= 1'b0;
            r_issued[r_tail]     <= 1'b0;
            r_tail               <= f_next(r_tail);
         end
         for (int i = 0; i < AQ_LENGTH; i++) begin
            if (i_exec_valid && r_valid[i] && (r_tag[i] == i_exec_tag)) begin
               r_addr_valid[i] <= 1'b1;
               r_addr[i]       <= i_exec_addr;
               r_wdata[i]      <= i_exec_wdata;
            end
         end
         if (w_fire) begin
            r_issued[w_issue_idx] <= 1'b1;
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= f_next(r_head);
         end
         r_count <= r_count + {{(BW_CNT-1){1'b0}}, w_alloc} - {{(BW_CNT-1){1'b0}}, w_pop};
         if (w_fire) begin
            r_lock <= 1'b0;
         end else if (o_lsrsv_valid && !r_lock) begin
            r_lock           <= 1'b1;
            r_lock_idx       <= w_sel_idx;
            r_hold_opcode    <= w_cur_opcode;
            r_hold_tag       <= w_cur_tag;
            r_hold_addr      <= w_cur_addr;
            r_hold_wdata     <= w_cur_wdata;
            r_hold_fwd_valid <= w_fwd_hit;
            r_hold_fwd_data  <= w_cur_fwd_data;
         end
      end
   end

endmodule
